morse_char_assembler: RTL and testbench

Downstream consumer of the Morse decoder FSM's single-cycle dot, dash, lg (letter gap) and wg (word gap) pulses. It accumulates dot/dash symbols into a code word and translates the completed code to ASCII. It presents each character on a valid/ready byte interface that feeds the display/UART stage. A word gap flushes any pending letter and then emits a space.

---
 rtl/morse_pkg.sv | 18 +
 rtl/morse_lut.sv | 64 ++++++
 rtl/morse_char_assembler.sv | 162 ++++++++++++++++
 tb/tb_morse_char_assembler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse character assembler.
// MORSE_PUNCT_EN widens letters to six symbols and adds punctuation codes.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      EMIT_CHAR,
      EMIT_SPACE
   } state_e;

   localparam int CODE_W = 6;
   localparam int LEN_W  = 3;

   localparam logic [7:0] ASCII_SPACE           = 8'h20;
   localparam logic [7:0] ASCII_UNKNOWN_DEFAULT = 8'h3F;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse code to ASCII translation keyed on {length, code}.
// MORSE_PUNCT_EN adds '.', ',', '?', '/', '='.
module morse_lut
   import morse_pkg::*;
#(
   parameter logic [7:0] ASCII_UNKNOWN = ASCII_UNKNOWN_DEFAULT
) (
   input  logic [LEN_W-1:0]  len,
   input  logic [CODE_W-1:0] code,
   output logic [7:0]        ascii
);

   // First symbol received sits in the MSB of the used bits; dash = 1.
   always_comb begin
      ascii = ASCII_UNKNOWN;
      case ({len, code})
         {3'd1, 6'b000000}: ascii = "E";
         {3'd1, 6'b000001}: ascii = "T";
         {3'd2, 6'b000000}: ascii = "I";
         {3'd2, 6'b000001}: ascii = "A";
         {3'd2, 6'b000010}: ascii = "N";
         {3'd2, 6'b000011}: ascii = "M";
         {3'd3, 6'b000000}: ascii = "S";
         {3'd3, 6'b000001}: ascii = "U";
         {3'd3, 6'b000010}: ascii = "R";
         {3'd3, 6'b000011}: ascii = "W";
         {3'd3, 6'b000100}: ascii = "D";
         {3'd3, 6'b000101}: ascii = "K";
         {3'd3, 6'b000110}: ascii = "G";
         {3'd3, 6'b000111}: ascii = "O";
         {3'd4, 6'b000000}: ascii = "H";
         {3'd4, 6'b000001}: ascii = "V";
         {3'd4, 6'b000010}: ascii = "F";
         {3'd4, 6'b000100}: ascii = "L";
         {3'd4, 6'b000110}: ascii = "P";
         {3'd4, 6'b000111}: ascii = "J";
         {3'd4, 6'b001000}: ascii = "B";
         {3'd4, 6'b001001}: ascii = "X";
         {3'd4, 6'b001010}: ascii = "C";
         {3'd4, 6'b001011}: ascii = "Y";
         {3'd4, 6'b001100}: ascii = "Z";
         {3'd4, 6'b001101}: ascii = "Q";
         {3'd5, 6'b011111}: ascii = "0";
         {3'd5, 6'b001111}: ascii = "1";
         {3'd5, 6'b000111}: ascii = "2";
         {3'd5, 6'b000011}: ascii = "3";
         {3'd5, 6'b000001}: ascii = "4";
         {3'd5, 6'b000000}: ascii = "5";
         {3'd5, 6'b010000}: ascii = "6";
         {3'd5, 6'b011000}: ascii = "7";
         {3'd5, 6'b011100}: ascii = "8";
         {3'd5, 6'b011110}: ascii = "9";
`ifdef MORSE_PUNCT_EN
         {3'd6, 6'b010101}: ascii = ".";
         {3'd6, 6'b110011}: ascii = ",";
         {3'd6, 6'b001100}: ascii = "?";
         {3'd5, 6'b010010}: ascii = "/";
         {3'd5, 6'b010001}: ascii = "=";
`endif
         default:           ascii = ASCII_UNKNOWN;
      endcase
   end

endmodule

// File: rtl/morse_char_assembler.sv
// Collects dot/dash pulses into letters and emits ASCII on a valid/ready byte port.
// MORSE_PUNCT_EN raises the letter length limit to six symbols.
module morse_char_assembler
   import morse_pkg::*;
#(
   parameter int         MAX_SYM            = 5,
   parameter logic [7:0] ASCII_UNKNOWN      = ASCII_UNKNOWN_DEFAULT,
   parameter bit         SUPPRESS_DUP_SPACE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dot,
   input  logic             dash,
   input  logic             lg,
   input  logic             wg,
   output logic [7:0]       char_data,
   output logic             char_valid,
   input  logic             char_ready,
   output logic [LEN_W-1:0] sym_count,
   output logic             overflow,
   output logic             overrun
);

`ifdef MORSE_PUNCT_EN
   localparam logic [LEN_W-1:0] SYM_LIMIT = LEN_W'(6);
`else
   localparam logic [LEN_W-1:0] SYM_LIMIT = LEN_W'(MAX_SYM);
`endif

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                bad_q, bad_d;
   logic [7:0]          char_data_q, char_data_d;
   logic                char_valid_q, char_valid_d;
   logic                space_pend_q, space_pend_d;
   logic                last_space_q, last_space_d;
   logic                overflow_q, overflow_d;
   logic                overrun_q, overrun_d;

   logic                busy;
   logic                acc_nonempty;
   logic                accept;
   logic [7:0]          lut_ascii;

   morse_lut #(
      .ASCII_UNKNOWN (ASCII_UNKNOWN)
   ) u_lut (
      .len   (len_q),
      .code  (code_q),
      .ascii (lut_ascii)
   );

   assign busy         = (state_q == EMIT_CHAR) || (state_q == EMIT_SPACE);
   assign acc_nonempty = (len_q != '0);
   assign accept       = char_valid_q && char_ready;

   always_comb begin
      // NOTE: every _d starts from its hold value so no path through this block infers a latch.
      state_d      = state_q;
      code_d       = code_q;
      len_d        = len_q;
      bad_d        = bad_q;
      char_data_d  = char_data_q;
      char_valid_d = char_valid_q;
      space_pend_d = space_pend_q;
      last_space_d = last_space_q;
      overrun_d    = overrun_q;
      overflow_d   = 1'b0;

      // Gaps act on the letter as it stood before this cycle's symbol.
      if (lg || wg) begin
         if (!busy) begin
            if (acc_nonempty) begin
               char_data_d  = bad_q ? ASCII_UNKNOWN : lut_ascii;
               char_valid_d = 1'b1;
               space_pend_d = wg;
               last_space_d = 1'b0;
               state_d      = EMIT_CHAR;
               code_d       = '0;
               len_d        = '0;
               bad_d        = 1'b0;
            end else if (wg && !(SUPPRESS_DUP_SPACE && last_space_q)) begin
               char_data_d  = ASCII_SPACE;
               char_valid_d = 1'b1;
               state_d      = EMIT_SPACE;
            end
         end else begin
            if (acc_nonempty) begin
               overrun_d = 1'b1;
               code_d    = '0;
               len_d     = '0;
               bad_d     = 1'b0;
            end
            if (wg && state_q == EMIT_CHAR) space_pend_d = 1'b1;
         end
      end

      if (busy && accept) begin
         if (state_q == EMIT_CHAR && space_pend_d) begin
            char_data_d = ASCII_SPACE;
            state_d     = EMIT_SPACE;
         end else begin
            char_valid_d = 1'b0;
            state_d      = IDLE;
            if (state_q == EMIT_SPACE) begin
               last_space_d = 1'b1;
               space_pend_d = 1'b0;
            end
         end
      end

      if (dot && dash) begin
         overflow_d = 1'b1;
      end else if (dot || dash) begin
         if (len_d == SYM_LIMIT) begin
            overflow_d = 1'b1;
            bad_d      = 1'b1;
         end else begin
            code_d = {code_d[CODE_W-2:0], dash};
            len_d  = len_d + LEN_W'(1);
         end
      end

      if (state_d == IDLE || state_d == COLLECT)
         state_d = (len_d != '0) ? COLLECT : IDLE;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      if (reset) begin
         state_q      <= IDLE;
         code_q       <= '0;
         len_q        <= '0;
         bad_q        <= 1'b0;
         char_data_q  <= 8'h00;
         char_valid_q <= 1'b0;
         space_pend_q <= 1'b0;
         last_space_q <= 1'b1;
         overflow_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         len_q        <= len_d;
         bad_q        <= bad_d;
         char_data_q  <= char_data_d;
         char_valid_q <= char_valid_d;
         space_pend_q <= space_pend_d;
         last_space_q <= last_space_d;
         overflow_q   <= overflow_d;
         overrun_q    <= overrun_d;
      end
   end

   assign char_data  = char_data_q;
   assign char_valid = char_valid_q;
   assign sym_count  = len_q;
   assign overflow   = overflow_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_morse_char_assembler.sv
// Randomized bench for morse_char_assembler against a string/queue reference model.
// Build with MORSE_PUNCT_EN to exercise the punctuation table.
module tb_morse_char_assembler;

`ifdef MORSE_PUNCT_EN
   localparam int MAXS = 6;
`else
   localparam int MAXS = 5;
`endif
   localparam bit SUPPRESS = 1'b1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       dot = 1'b0, dash = 1'b0, lg = 1'b0, wg = 1'b0;
   logic       char_ready = 1'b0;
   logic [7:0] char_data;
   logic       char_valid;
   logic [2:0] sym_count;
   logic       overflow, overrun;

   int n_tests = 0;
   int n_fail  = 0;

   morse_char_assembler dut (
      .clk        (clk),
      .reset      (reset),
      .dot        (dot),
      .dash       (dash),
      .lg         (lg),
      .wg         (wg),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .sym_count  (sym_count),
      .overflow   (overflow),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Reference model: letter as a string of '.'/'-', output bytes as a queue.
   byte unsigned tab[string];
   string        cur;
   bit           bad;
   bit           lws;
   bit           ovf_e;
   bit           ovr_e;
   byte unsigned outq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic byte unsigned decode(input string s, input bit b);
      if (b || !tab.exists(s)) return 8'h3F;
      return tab[s];
   endfunction

   function automatic void model_reset();
      cur = "";
      bad = 1'b0;
      lws = 1'b1;
      ovf_e = 1'b0;
      ovr_e = 1'b0;
      outq.delete();
   endfunction

   function automatic void model_step(input logic d, input logic da, input logic l,
                                      input logic w, input logic r);
      bit busy;
      busy  = (outq.size() != 0);
      ovf_e = 1'b0;
      if (l || w) begin
         if (!busy) begin
            if (cur.len() != 0) begin
               outq.push_back(decode(cur, bad));
               if (w) outq.push_back(8'h20);
               lws = 1'b0;
               cur = "";
               bad = 1'b0;
            end else if (w && !(SUPPRESS && lws)) begin
               outq.push_back(8'h20);
            end
         end else begin
            if (cur.len() != 0) begin
               ovr_e = 1'b1;
               cur   = "";
               bad   = 1'b0;
            end
            if (w && outq.size() == 1 && outq[0] != 8'h20) outq.push_back(8'h20);
         end
      end
      if (busy && r) begin
         if (outq[0] == 8'h20) lws = 1'b1;
         void'(outq.pop_front());
      end
      if (d && da) begin
         ovf_e = 1'b1;
      end else if (d || da) begin
         if (cur.len() == MAXS) begin
            ovf_e = 1'b1;
            bad   = 1'b1;
         end else if (da) begin
            cur = {cur, "-"};
         end else begin
            cur = {cur, "."};
         end
      end
   endfunction

   task automatic compare_all();
      check("valid", 32'(char_valid), 32'(outq.size() != 0));
      if (outq.size() != 0) check("data", 32'(char_data), 32'(outq[0]));
      check("sym_count", 32'(sym_count), 32'(cur.len()));
      check("overflow", 32'(overflow), 32'(ovf_e));
      check("overrun", 32'(overrun), 32'(ovr_e));
   endtask

   task automatic cycle(input logic d, input logic da, input logic l, input logic w,
                        input logic r);
      @(negedge clk);
      dot = d; dash = da; lg = l; wg = w; char_ready = r;
      model_step(d, da, l, w, r);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, r);
   endtask

   task automatic send(input string s, input logic r);
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] == "-") cycle(1'b0, 1'b1, 1'b0, 1'b0, r);
         else             cycle(1'b1, 1'b0, 1'b0, 1'b0, r);
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      dot = 1'b0; dash = 1'b0; lg = 1'b0; wg = 1'b0; char_ready = 1'b0;
      model_reset();
      repeat (n) @(posedge clk);
      #1;
      check("rst_valid", 32'(char_valid), 32'd0);
      check("rst_data", 32'(char_data), 32'h00);
      check("rst_sym", 32'(sym_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                           ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                           "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                           "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                           "--...", "---..", "----."};
      string glyphs = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
      int    rp = 90;
      for (int i = 0; i < 36; i++) tab[codes[i]] = glyphs[i];
`ifdef MORSE_PUNCT_EN
      tab[".-.-.-"] = 8'h2E;
      tab["--..--"] = 8'h2C;
      tab["..--.."] = 8'h3F;
      tab["-..-."]  = 8'h2F;
      tab["-...-"]  = 8'h3D;
`endif

      do_reset(3);

      // 'A' one cycle after lg, sym_count 0->1->2->0
      send(".-", 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("A_data", 32'(char_data), 32'h41);
      idle(2, 1'b1);

      // 'B' then a space; a repeated wg is suppressed
      send("-...", 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("B_data", 32'(char_data), 32'h42);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("B_space", 32'(char_data), 32'h20);
      idle(1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("dup_space", 32'(char_valid), 32'd0);
      idle(2, 1'b1);

      // 'E' stalled ten cycles while the next letter is collected
      send(".", 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3, 1'b0);
      send(".-", 1'b0);
      idle(5, 1'b0);
      check("E_held", 32'(char_data), 32'h45);
      idle(1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("A2_data", 32'(char_data), 32'h41);
      idle(2, 1'b1);

      // Overflow past the symbol limit decodes to '?'
      send(".....", 1'b1);
`ifndef MORSE_PUNCT_EN
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("ovf_pulse", 32'(overflow), 32'd1);
`endif
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef MORSE_PUNCT_EN
      check("five_dots", 32'(char_data), 32'h35);
`else
      check("ovf_char", 32'(char_data), 32'h3F);
`endif
      idle(2, 1'b1);
`ifdef MORSE_PUNCT_EN
      send(".-.-.-", 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("period", 32'(char_data), 32'h2E);
      idle(2, 1'b1);
`endif

      // Overrun: lg while 'E' is stalled; then reset mid-emit
      send(".", 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send(".", 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("overrun_set", 32'(overrun), 32'd1);
      idle(3, 1'b0);
      check("overrun_sticky", 32'(overrun), 32'd1);
      check("E_only", 32'(char_data), 32'h45);
      do_reset(1);

      // Randomized traffic with varying downstream back-pressure
      for (int i = 0; i < 4000; i++) begin
         logic d, da, l, w, r;
         if (i % 64 == 0) begin
            case ($urandom_range(2))
               0:       rp = 15;
               1:       rp = 60;
               default: rp = 97;
            endcase
         end
         d  = ($urandom_range(99) < 14);
         da = ($urandom_range(99) < 14);
         l  = ($urandom_range(99) < 7);
         w  = ($urandom_range(99) < 3);
         r  = ($urandom_range(99) < rp);
         cycle(d, da, l, w, r);
         if (i == 2500) do_reset(2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
